// File: rtl/adap_quan.sv
// Iterative adaptive quantizer: |D| to log domain (LOG), subtract scale (SUB),
// then compare against decision levels one per cycle (QUAN). Optional macro RATE_40K_EN adds the 40k path.
module adap_quan (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_en,
    output logic        scan_out0,
    input  logic [15:0] D,
    input  logic [12:0] Y,
    input  logic [1:0]  RATE,
    input  logic        D_VALID,
    output logic        D_READY,
    output logic [4:0]  I,
    output logic        I_VALID
);

    typedef enum logic [2:0] {S_IDLE, S_LOG, S_SUB, S_QUAN, S_DONE} state_t;

    // Decision levels in ascending order; the last entry of each table is padding.
`ifdef RATE_40K_EN
    localparam logic signed [11:0] THR40 [16] = '{
        -12'sd122, -12'sd16, 12'sd68, 12'sd139, 12'sd198, 12'sd250, 12'sd298, 12'sd339,
        12'sd378, 12'sd413, 12'sd445, 12'sd475, 12'sd502, 12'sd528, 12'sd553, 12'sd0};
`endif
    localparam logic signed [11:0] THR32 [8] = '{
        -12'sd124, 12'sd80, 12'sd178, 12'sd246, 12'sd300, 12'sd349, 12'sd400, 12'sd0};
    localparam logic signed [11:0] THR24 [4] = '{12'sd8, 12'sd218, 12'sd331, 12'sd0};
    localparam logic signed [11:0] THR16     = 12'sd261;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_ds;
    logic [14:0]        r_sh;
    logic [3:0]         r_e;
    logic [3:0]         r_cnt;
    logic [1:0]         r_rate;
    logic [10:0]        r_yq;
    logic signed [11:0] r_dln;
    logic [3:0]         r_mag;
    logic [4:0]         r_i;
    logic               r_ivalid;

    logic [15:0]        w_neg;
    logic [14:0]        w_mag;
    logic [10:0]        w_dl;
    logic [1:0]         w_rate_in;
    logic [3:0]         w_last_q;
    logic [4:0]         w_mask;
    logic signed [11:0] w_thr;
    logic [4:0]         w_code;
    logic               w_unused;

    assign w_unused  = &{1'b0, scan_in0, scan_en, Y[1:0], w_neg[15]};
    assign scan_out0 = 1'b0;
    assign I         = r_i;
    assign I_VALID   = r_ivalid;

    // -32768 has no positive 16-bit twin, so it saturates to the largest magnitude.
    assign w_neg = 16'd0 - D;
    assign w_mag = (D == 16'h8000) ? 15'h7FFF : (D[15] ? w_neg[14:0] : D[14:0]);
    assign w_dl  = {r_e, r_sh[13:7]};

`ifdef RATE_40K_EN
    assign w_rate_in = RATE;
`else
    assign w_rate_in = (RATE == 2'b00) ? 2'b01 : RATE;
`endif

    always_comb begin
        w_last_q = 4'd6;
        w_mask   = 5'h0F;
        w_thr    = THR32[r_cnt[2:0]];
        case (r_rate)
`ifdef RATE_40K_EN
            2'b00: begin
                w_last_q = 4'd14;
                w_mask   = 5'h1F;
                w_thr    = THR40[r_cnt];
            end
`endif
            2'b10: begin
                w_last_q = 4'd2;
                w_mask   = 5'h07;
                w_thr    = THR24[r_cnt[1:0]];
            end
            2'b11: begin
                w_last_q = 4'd0;
                w_mask   = 5'h03;
                w_thr    = THR16;
            end
            default: ;
        endcase
    end

    assign w_code = (r_ds ? ~{1'b0, r_mag} : {1'b0, r_mag}) & w_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        D_READY      = 1'b0;
        case (r_state)
            S_IDLE: begin
                D_READY = 1'b1;
                if (D_VALID) w_state_next = S_LOG;
            end
            S_LOG:   if (r_cnt == 4'd14) w_state_next = S_SUB;
            S_SUB:   w_state_next = S_QUAN;
            S_QUAN:  if (r_cnt == w_last_q) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ds     <= 1'b0;
            r_sh     <= '0;
            r_e      <= '0;
            r_cnt    <= '0;
            r_rate   <= '0;
            r_yq     <= '0;
            r_dln    <= '0;
            r_mag    <= '0;
            r_i      <= '0;
            r_ivalid <= 1'b0;
        end else begin
            r_ivalid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: if (D_VALID) begin
                    r_ds   <= D[15];
                    r_sh   <= w_mag;
                    r_e    <= 4'd14;
                    r_cnt  <= '0;
                    r_rate <= w_rate_in;
                    r_yq   <= Y[12:2];
                    r_mag  <= '0;
                end
                S_LOG: begin
                    // Normalise until the leading one reaches bit 14 or the exponent bottoms out.
                    if (!r_sh[14] && (r_e != 4'd0)) begin
                        r_sh <= {r_sh[13:0], 1'b0};
                        r_e  <= r_e - 4'd1;
                    end
                    r_cnt <= (r_cnt == 4'd14) ? 4'd0 : r_cnt + 4'd1;
                end
                S_SUB: r_dln <= {1'b0, w_dl} - {1'b0, r_yq};
                S_QUAN: begin
                    if (r_dln >= w_thr) r_mag <= r_mag + 4'd1;
                    r_cnt <= r_cnt + 4'd1;
                end
                S_DONE: r_i <= w_code;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adap_quan.md
# adap_quan

Sequential G.726 adaptive quantizer for the mcac_bs datapath: converts a 16-bit difference signal D into an ADPCM codeword I, given scale factor Y and coding RATE. It is the encoder-side counterpart of the inverse adaptive quantizer, whose I input it feeds. It uses an iterative LOG → SUBTB → QUAN pipeline with a valid/ready input handshake and a one-cycle result strobe.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- scan_in0  in  1  scan chain input (DFT stitched at synthesis)
- scan_en  in  1  scan enable
- scan_out0  out  1  scan chain output; RTL drives 0
- D  in  16  difference signal, two's complement
- Y  in  13  quantizer scale factor, unsigned
- RATE  in  2  00 = 40k (5-bit I), 01 = 32k (4-bit), 10 = 24k (3-bit), 11 = 16k (2-bit)
- D_VALID  in  1  D/Y/RATE valid
- D_READY  out  1  block idle, can accept
- I  out  5  codeword, right-justified; unused MSBs 0
- I_VALID  out  1  one-cycle strobe, I valid

## Operation
- States: IDLE, LOG, SUB, QUAN, DONE.
- IDLE:
  - D_READY = 1.
  - On D_VALID=1, capture D, Y and RATE.
  - DS = D[15].
  - MAG = |D| as a 15-bit value; D = -32768 saturates to 0x7FFF.
  - Set SH = MAG, E = 14, cnt = 0. Go to LOG.
- LOG: runs exactly 15 cycles.
  - Each cycle: if SH[14]=0 and E≠0, then SH <<= 1 and E -= 1.
  - On exit: DL = {E[3:0], SH[13:7]} (11 bits). MAG = 0 gives DL = 0.
- SUB: one cycle.
  - DLN = (DL + 4096 − (Y >> 2)) mod 4096, 12 bits.
  - DLN is treated as signed 12-bit.
- QUAN: T cycles, where T = 15/7/3/1 for 40k/32k/24k/16k.
  - Cycle k compares DLN (signed) against ROM threshold THR[rate][k].
  - If DLN ≥ THR[rate][k], mag += 1.
  - THR is the G.726 QUAN decision-level table for each rate, as signed 12-bit DLN values in ascending order.
- DONE: one cycle.
  - I = DS ? ~mag : mag, over N bits (N = 5/4/3/2); upper bits zero.
  - I_VALID = 1. Return to IDLE.
- RATE is sampled only at acceptance. Changes on the port mid-conversion are ignored.
- D_VALID is ignored outside IDLE. No input queueing.
- I holds its value until the next DONE.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, D_READY = 1, I = 0, I_VALID = 0, scan_out0 = 0.
  - All internal registers cleared.
- Latency: acceptance edge is edge 0; I_VALID is high during the cycle after edge 17+T.
  - 40k: 32, 32k: 24, 24k: 20, 16k: 18 clocks.
- Throughput: one conversion per 18+T cycles. D_READY returns high the cycle after DONE.
- D_READY is low from the cycle after acceptance through DONE inclusive.
- Reset asserted mid-conversion: aborts immediately, no I_VALID is produced, and the block is in IDLE with D_READY = 1 after release.
- D_VALID held high continuously: the next sample is accepted on the first IDLE cycle after DONE.

## Configuration
- RATE_40K_EN defined: RATE=00 runs the 40k path (15 thresholds, 5-bit I).
- Undefined:
  - The 40k ROM and 5-bit path are omitted.
  - RATE=00 is processed exactly as RATE=01 (32k, T = 7, I[4] = 0).
  - Latency for RATE=00 is 24.

## Test plan
- Reset check: D_VALID=1 with reset low → D_READY=1, I=0, I_VALID=0. Release reset → acceptance on the first clock.
- 32k positive extreme: D=16'h7FFF, Y=0, RATE=01 → DL=1919; I_VALID exactly 24 cycles after acceptance with I=5'b00111.
- 32k small-signal extremes, Y=8188 (DLN=2049, most negative):
  - D=0 → I=5'b00000.
  - D=16'hFFFF → I=5'b01111.
- 40k negative extreme: D=16'h8000, Y=0, RATE=00:
  - With RATE_40K_EN → I=5'b10000 at latency 32.
  - Without it → I=5'b01000 at latency 24.
- Back-to-back conversions with D_VALID held high and RATE=11 then 10:
  - I_VALID 18 then 20 cycles after the respective acceptances.
  - D_READY low throughout each conversion.
  - RATE toggled mid-conversion has no effect.
- Mid-conversion reset: assert reset at cycle 10 of LOG → no I_VALID; I=0; after release the next sample converts correctly.
